// File: rtl/input_fifo.sv
// Per-input-port flit buffer for the NoC router. Flits are stored in
// arrival order and the head flit is presented first-word-fall-through to
// the LBDR routing stage. Each accepted pop returns one credit upstream.
module input_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  overflow
);

  // One extra bit so the count can hold DEPTH itself.
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  rd_req;
  logic                  rd;
  logic                  wr;
  logic [DATA_WIDTH-1:0] head;

  // Pop/push qualification and next occupancy. Several grants in one
  // cycle collapse into a single pop; a grant on an empty buffer is ignored.
  always_comb begin
    rd_req    = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    rd        = rd_req & ~empty;
    wr        = valid_in & (~full | rd);
    count_nxt = count;
    if (wr && !rd) begin
      count_nxt = count + CNT_WIDTH'(1);
    end else if (rd && !wr) begin
      count_nxt = count - CNT_WIDTH'(1);
    end
  end

  // Pointers, occupancy, registered flags, credit pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      credit_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      count      <= count_nxt;
      empty      <= (count_nxt == CNT_WIDTH'(0));
      full       <= (count_nxt == CNT_WIDTH'(DEPTH));
      credit_out <= rd;
      if (valid_in && full && !rd) begin
        overflow <= 1'b1;
      end
    end
  end

  // Flit storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Head flit is masked to zero while nothing is stored.
  always_comb begin
    head = empty ? '0 : mem[rd_ptr];
  end

  assign data_out = head;
  assign flit_id  = head[DATA_WIDTH-1 -: 3];
  assign dst_addr = head[DATA_WIDTH-4 -: 4];

endmodule

// File: tb/tb_input_fifo.sv
// Directed bench for input_fifo with a popped-flit scoreboard.
module tb_input_fifo;

  localparam int unsigned DW = 32;
  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          read_en_N = 1'b0;
  logic          read_en_E = 1'b0;
  logic          read_en_W = 1'b0;
  logic          read_en_S = 1'b0;
  logic          read_en_L = 1'b0;
  logic [DW-1:0] data_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic          empty;
  logic          full;
  logic          credit_out;
  logic          overflow;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  input_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .PTR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .data_out(data_out), .flit_id(flit_id), .dst_addr(dst_addr),
    .empty(empty), .full(full), .credit_out(credit_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [3:0] dst,
                                       input logic [24:0] pl);
    return {id, dst, pl};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [4:0] re);
    valid_in = v;
    data_in  = d;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = re;
    if (v) begin
      if (!full || (|re)) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    drive(1'b1, d, 5'b00000);
  endtask

  task automatic pop(input logic [4:0] re);
    drive(1'b0, '0, re);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: a pop observed at one negedge must give a credit at the next,
  // and the flit that was at the head must match the scoreboard front.
  task automatic monitor();
    logic          cap_v;
    logic [DW-1:0] cap_d;
    logic [DW-1:0] exp;
    cap_v = 1'b0;
    cap_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap_v = 1'b0;
      end else begin
        if (cap_v || credit_out) begin
          tests++;
          if (credit_out !== cap_v) begin
            fails++;
            $display("FAIL credit_pulse: credit_out=%b expected %b", credit_out, cap_v);
          end
          if (cap_v) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL pop_order: popped %h but scoreboard empty", cap_d);
            end else begin
              exp = exp_q.pop_front();
              if (cap_d !== exp) begin
                fails++;
                $display("FAIL pop_order: popped %h expected %h", cap_d, exp);
              end
            end
          end
        end
        cap_v = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty;
        cap_d = data_out;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] f [4];
    logic [DW-1:0] w;
    fork
      monitor();
    join_none

    // T1 reset with valid_in held high
    do_reset();
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_full", 32'(full), 32'd0);
    chk("t1_credit", 32'(credit_out), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_data_out", data_out, 32'd0);
    chk("t1_dst_addr", 32'(dst_addr), 32'd0);

    // T2 fill/drain a four-flit packet
    f[0] = mk(HEADER, 4'hA, 25'h000_0011);
    f[1] = mk(PAYLOAD, 4'h0, 25'h123_4567);
    f[2] = mk(PAYLOAD, 4'h0, 25'h0AB_CDEF);
    f[3] = mk(TAIL, 4'h0, 25'h1FF_FFFF);
    push(f[0]);
    chk("t2_head_latency", data_out, f[0]);
    chk("t2_not_empty", 32'(empty), 32'd0);
    push(f[1]);
    push(f[2]);
    chk("t2_full_at3", 32'(full), 32'd0);
    push(f[3]);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_flit_id", 32'(flit_id), 32'(HEADER));
    chk("t2_dst_addr", 32'(dst_addr), 32'hA);
    for (int i = 0; i < 4; i++) pop(5'b01000);
    chk("t2_drained_empty", 32'(empty), 32'd1);
    chk("t2_drained_data", data_out, 32'd0);
    pop(5'b00000);

    // T3 overflow: fifth write with no pop is dropped
    for (int i = 0; i < 4; i++) push(mk(PAYLOAD, 4'(i), 25'(32'h100 + 32'(i))));
    drive(1'b1, mk(TAIL, 4'hF, 25'h0BAD), 5'b00000);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_head_kept", data_out, mk(PAYLOAD, 4'd0, 25'h100));
    for (int i = 0; i < 3; i++) pop(5'b00100);
    chk("t3_one_left_empty", 32'(empty), 32'd0);
    chk("t3_one_left_full", 32'(full), 32'd0);
    chk("t3_one_left_head", data_out, mk(PAYLOAD, 4'd3, 25'h103));
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    pop(5'b00010);
    pop(5'b00000);
    do_reset();
    chk("t3_overflow_cleared", 32'(overflow), 32'd0);

    // T4 simultaneous read and write while full
    for (int i = 0; i < 4; i++) push(mk(HEADER, 4'(i + 4), 25'(32'h200 + 32'(i))));
    drive(1'b1, mk(TAIL, 4'h8, 25'h204), 5'b10000);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_credit", 32'(credit_out), 32'd1);
    chk("t4_head", data_out, mk(HEADER, 4'd5, 25'h201));
    for (int i = 0; i < 4; i++) pop(5'b10000);
    chk("t4_empty", 32'(empty), 32'd1);
    pop(5'b00000);

    // T5 read on empty, then pointer wrap with write/pop pairs
    pop(5'b00001);
    chk("t5_no_credit", 32'(credit_out), 32'd0);
    chk("t5_still_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 10; i++) begin
      w = mk(PAYLOAD, 4'(i), 25'(32'(i) * 37 + 5));
      push(w);
      chk("t5_wrap_head", data_out, w);
      pop(5'b00001);
    end
    chk("t5_wrap_empty", 32'(empty), 32'd1);
    pop(5'b00000);

    // T6 two grants in one cycle count as one pop
    push(mk(HEADER, 4'h3, 25'h300));
    push(mk(TAIL, 4'h0, 25'h301));
    pop(5'b10010);
    chk("t6_credit", 32'(credit_out), 32'd1);
    chk("t6_empty", 32'(empty), 32'd0);
    chk("t6_head", data_out, mk(TAIL, 4'h0, 25'h301));
    pop(5'b00000);
    chk("t6_single_pulse", 32'(credit_out), 32'd0);
    chk("t6_count1_head", data_out, mk(TAIL, 4'h0, 25'h301));
    pop(5'b01000);
    chk("t6_drained", 32'(empty), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
